// File: rtl/athena_hiscore_save.sv
// rtl/athena_hiscore_save.sv - hi-score table save engine: side RAM to packed 32-bit dataslot words
//
// Purpose:
//   On a save request, pause the game CPU, read the Athena / Fighting Golf
//   hi-score table out of side RAM and stream it as big-endian packed
//   32-bit words with a valid/ready handshake.
//
// Ports:
//   game_clk_i          sole clock, rising edge
//   reset_i             synchronous active-high reset
//   is_fighting_golf_i  selects golf table size/offset, latched at save start
//   table_valid_i       table in side RAM is initialised or loaded
//   save_req_i          one-cycle save request pulse
//   hs_pause_req_o      CPU pause request
//   pause_cpu_i         CPU paused, side RAM owned by this block
//   ram_addr_o          side-RAM address
//   ram_nCS_o           side-RAM chip select, active low
//   ram_nWE_o           side-RAM write enable, active low (always 1)
//   ram_data_out_i      side-RAM read data, valid one cycle after the address
//   word_valid_o        word_data_o holds a packed word
//   word_ready_i        sink accepts the word
//   word_data_o         packed table word
//   word_last_o         current word is the final one
//   busy_o              save in progress
//   done_o              one-cycle pulse after the final word is accepted

module athena_hiscore_save #(
   parameter logic [31:0] SIZE_ATHENA   = 32'h72,
   parameter logic [10:0] OFFSET_ATHENA = 11'h650,
   parameter logic [31:0] SIZE_GOLF     = 32'h50,
   parameter logic [10:0] OFFSET_GOLF   = 11'h770
) (
   input  logic        game_clk_i,
   input  logic        reset_i,
   input  logic        is_fighting_golf_i,
   input  logic        table_valid_i,
   input  logic        save_req_i,
   output logic        hs_pause_req_o,
   input  logic        pause_cpu_i,
   output logic [10:0] ram_addr_o,
   output logic        ram_nCS_o,
   output logic        ram_nWE_o,
   input  logic [7:0]  ram_data_out_i,
   output logic        word_valid_o,
   input  logic        word_ready_i,
   output logic [31:0] word_data_o,
   output logic        word_last_o,
   output logic        busy_o,
   output logic        done_o
);

   // Table lengths fit the 8-bit byte index.
   localparam logic [7:0] SIZE_A8 = SIZE_ATHENA[7:0];
   localparam logic [7:0] SIZE_G8 = SIZE_GOLF[7:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAUSE,
      S_READ,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  size_q, size_d;
   logic [10:0] offset_q, offset_d;
   logic [7:0]  base_q, base_d;     // byte index of the first byte of the current word
   logic [2:0]  iss_q, iss_d;       // bytes of the current word addressed so far
   logic [2:0]  cap_q, cap_d;       // bytes of the current word captured so far
   logic        pend_q, pend_d;     // an address went out last cycle, its data is on the bus now
   logic [31:0] data_q, data_d;

   logic [7:0]  rem;
   logic [2:0]  nb;
   logic        last_word;
   logic        issue;

   assign rem       = size_q - base_q;
   assign nb        = (rem >= 8'd4) ? 3'd4 : rem[2:0];
   assign last_word = (rem <= 8'd4);
   // Reads are only issued while the CPU is actually held off.
   assign issue     = (state_q == S_READ) && pause_cpu_i && (iss_q < nb);

   always_ff @(posedge game_clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         size_q   <= 8'd0;
         offset_q <= 11'd0;
         base_q   <= 8'd0;
         iss_q    <= 3'd0;
         cap_q    <= 3'd0;
         pend_q   <= 1'b0;
         data_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         size_q   <= size_d;
         offset_q <= offset_d;
         base_q   <= base_d;
         iss_q    <= iss_d;
         cap_q    <= cap_d;
         pend_q   <= pend_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      size_d   = size_q;
      offset_d = offset_q;
      base_d   = base_q;
      iss_d    = iss_q;
      cap_d    = cap_q;
      pend_d   = pend_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (save_req_i && table_valid_i) begin
               size_d   = is_fighting_golf_i ? SIZE_G8 : SIZE_A8;
               offset_d = is_fighting_golf_i ? OFFSET_GOLF : OFFSET_ATHENA;
               base_d   = 8'd0;
               iss_d    = 3'd0;
               cap_d    = 3'd0;
               pend_d   = 1'b0;
               data_d   = 32'd0;
               state_d  = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (pause_cpu_i) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            pend_d = issue;
            if (issue) begin
               iss_d = iss_q + 3'd1;
            end
            if (!pause_cpu_i) begin
               // Lost the bus: drop any in-flight byte and re-read from the
               // first uncaptured byte once the pause returns.
               iss_d = cap_q;
            end else if (pend_q) begin
               case (cap_q[1:0])
                  2'd0:    data_d[31:24] = ram_data_out_i;
                  2'd1:    data_d[23:16] = ram_data_out_i;
                  2'd2:    data_d[15:8]  = ram_data_out_i;
                  default: data_d[7:0]   = ram_data_out_i;
               endcase
               cap_d = cap_q + 3'd1;
               if ((cap_q + 3'd1) == nb) begin
                  state_d = S_PRESENT;
               end
            end
         end
         S_PRESENT: begin
            if (word_ready_i) begin
               if (last_word) begin
                  state_d = S_DONE;
               end else begin
                  base_d  = base_q + 8'd4;
                  iss_d   = 3'd0;
                  cap_d   = 3'd0;
                  pend_d  = 1'b0;
                  data_d  = 32'd0;
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      hs_pause_req_o = (state_q == S_PAUSE) || (state_q == S_READ) || (state_q == S_PRESENT);
      ram_nCS_o      = !issue;
      ram_addr_o     = issue ? (offset_q + {3'b000, base_q} + {8'h00, iss_q}) : 11'd0;
      ram_nWE_o      = 1'b1;
      word_valid_o   = (state_q == S_PRESENT);
      word_last_o    = (state_q == S_PRESENT) && last_word;
      word_data_o    = data_q;
      busy_o         = (state_q != S_IDLE);
      done_o         = (state_q == S_DONE);
   end

endmodule

// File: doc/athena_hiscore_save.md
# athena_hiscore_save

Saves the Athena / Fighting Golf hi-score table from side RAM back to the host hi-score dataslot. On a save request it pauses the game CPU, reads the table bytes out of side RAM and streams them as packed 32-bit bridge words to the core dataslot write path. It runs in the game clock domain and complements the hi-score load path, which writes the dataslot contents into the same side-RAM region.

## Interface
Parameters:
- `SIZE_ATHENA`, 32'h72: table length in bytes, Athena.
- `OFFSET_ATHENA`, 11'h650: table side-RAM base, Athena.
- `SIZE_GOLF`, 32'h50: table length in bytes, Fighting Golf.
- `OFFSET_GOLF`, 11'h770: table side-RAM base, Fighting Golf.

Ports:
- `game_clk  in  1`: sole clock. One clock; all logic on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `is_fighting_golf  in  1`: selects the golf size/offset; latched at save start.
- `table_valid  in  1`: level; the hi-score table in side RAM is initialised or loaded.
- `save_req  in  1`: one-cycle pulse requesting a save, already synchronised to `game_clk`.
- `hs_pause_req  out  1`: requests a CPU pause.
- `pause_cpu  in  1`: the CPU is paused and the block owns the side-RAM lines.
- `ram_addr  out  11`: side-RAM address.
- `ram_nCS  out  1`: side-RAM chip select, active low.
- `ram_nWE  out  1`: side-RAM write enable, active low. Tied to 1; the block only reads.
- `ram_data_out  in  8`: side-RAM read data. Valid the cycle after the address is driven with `ram_nCS`=0.
- `word_valid  out  1`: `word_data` holds a packed word.
- `word_ready  in  1`: the sink accepts the word.
- `word_data  out  32`: packed table word.
- `word_last  out  1`: the current word is the final one.
- `busy  out  1`: a save is in progress (any state other than IDLE).
- `done  out  1`: one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, PAUSE, READ, PRESENT, DONE.
- IDLE
  - `save_req` && `table_valid`: latch size/offset from `is_fighting_golf`, clear the byte index, go to PAUSE.
  - `save_req` while `table_valid`=0: ignored, no `done`.
- PAUSE: `hs_pause_req`=1. When `pause_cpu`=1, go to READ.
- READ: for each byte index k, drive `ram_addr`=offset+k with `ram_nCS`=0. Capture `ram_data_out` on the following cycle.
  - Up to 4 bytes make one word. Then go to PRESENT.
  - If fewer than 4 bytes remain, the final word holds only those bytes.
- Packing (bridge byte order): byte 4w+0 goes to `word_data[31:24]`, 4w+1 to [23:16], 4w+2 to [15:8], 4w+3 to [7:0]. Unused lanes of the final word are 0.
- PRESENT
  - `word_valid`=1; `word_last`=1 when this word contains byte size-1.
  - On `word_valid` && `word_ready`: if last, go to DONE; otherwise go to READ for the next word.
  - `word_data` is stable while `word_valid`=1.
- DONE: `done`=1 for one cycle, `hs_pause_req`=0, then go to IDLE.
- `hs_pause_req` is 1 in PAUSE, READ and PRESENT, and 0 otherwise.
- If `pause_cpu` drops during READ, the block stops issuing addresses (`ram_nCS`=1). Any in-flight byte is discarded. When `pause_cpu` returns, reading resumes at the same index. `hs_pause_req` stays high.
- `save_req` while `busy`=1: ignored.
- Word count is ceil(size/4): Athena 114 bytes gives 29 words (the last carries 2 bytes in [31:16]); Golf 80 bytes gives 20 words.
- The byte index is 8 bits and never exceeds size.

## Timing
- Reset values: `hs_pause_req`=0, `ram_addr`=0, `ram_nCS`=1, `ram_nWE`=1, `word_valid`=0, `word_data`=0, `word_last`=0, `busy`=0, `done`=0. State is IDLE.
- Reset asserted mid-save returns to IDLE on the next edge. `hs_pause_req` drops and no `done` is issued.
- `save_req` in cycle t: `busy`=`hs_pause_req`=1 in cycle t+1.
- `pause_cpu`=1 in cycle p (in PAUSE): first address driven in cycle p+1.
- Full word: addresses in 4 consecutive cycles c..c+3. `word_valid`=1 in cycle c+5.
- After a non-last word is accepted in cycle a, the next address is driven in cycle a+1.
- Final word accepted in cycle a: `done`=1 and `hs_pause_req`=0 in cycle a+1; `busy`=0 in a+2.
- `word_ready` may be held low indefinitely. No RAM access occurs in PRESENT.

## Test plan
- Athena save: `table_valid`=1, `is_fighting_golf`=0, RAM[0x650+k]=k, `word_ready`=1, pulse `save_req` → 29 words. First is 32'h00010203. Last is 32'h70710000 with `word_last`=1. Addresses run 0x650..0x6C1. One `done`.
- Golf save: `is_fighting_golf`=1, RAM[0x770+k]=8'hA0+k → 20 words. First is 32'hA0A1A2A3. Last is 32'hECEDEEEF. Addresses run 0x770..0x7BF.
- Backpressure: `word_ready` random with 30% high → identical word sequence. `word_data` stable while stalled. No `ram_nCS`=0 during PRESENT.
- Guard: `save_req` with `table_valid`=0 → `busy` stays 0, no RAM access. Second `save_req` mid-save → ignored, exactly one `done`.
- Pause handshake: `pause_cpu` delayed 10 cycles → no address before it. Drop `pause_cpu` for 3 cycles mid-READ → no bytes lost or duplicated.
- Reset mid-READ → all outputs return to reset values next cycle. A fresh save completes correctly.
